// File: rtl/fbuf_arbiter.sv
// fbuf_arbiter: single-port RAM arbiter for display reads, buffered host writes and accelerator access.
module fbuf_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int HDEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  input  logic          host_write,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_ovf_clr,
  output logic          host_ovf,
  input  logic          acc_req,
  input  logic          acc_we,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_wdata,
  output logic          acc_gnt,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(HDEPTH);
  typedef enum logic [1:0] {T_NONE, T_VGA, T_ACC} tag_t;
  logic [AW-1:0] fa_q [HDEPTH];
  logic [DW-1:0] fd_q [HDEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q, cnt_d;
  tag_t          tag_q, tag_d;
  logic          ptr_q, ovf_q, ovf_d, full, host_gnt, push, drop;
  logic [DW-1:0] vhold_q, ahold_q;
  // ptr_q=0 favours the host buffer, 1 favours the accelerator
  always_comb begin
    full      = cnt_q == (PW+1)'(HDEPTH);
    vga_gnt   = reset_n & vga_req;
    host_gnt  = reset_n & ~vga_req & (cnt_q != '0) & (full | ~acc_req | ~ptr_q);
    acc_gnt   = reset_n & ~vga_req & acc_req & ~host_gnt;
    push      = host_write & (~full | host_gnt);
    drop      = host_write & full & ~host_gnt;
    cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(host_gnt);
    ovf_d     = drop | (ovf_q & ~host_ovf_clr);
    mem_addr  = vga_req ? vga_addr : host_gnt ? fa_q[rp_q] : acc_addr;
    mem_we    = host_gnt | (acc_gnt & acc_we);
    mem_wdata = host_gnt ? fd_q[rp_q] : acc_wdata;
    tag_d     = vga_gnt ? T_VGA : (acc_gnt & ~acc_we) ? T_ACC : T_NONE;
    vga_rvalid = tag_q == T_VGA;
    acc_rvalid = tag_q == T_ACC;
    vga_rdata  = vga_rvalid ? mem_rdata : vhold_q;
    acc_rdata  = acc_rvalid ? mem_rdata : ahold_q;
    host_ovf   = ovf_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      tag_q   <= T_NONE;
      ptr_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vhold_q <= '0;
      ahold_q <= '0;
    end else begin
      wp_q    <= wp_q + PW'(push);
      rp_q    <= rp_q + PW'(host_gnt);
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      ptr_q   <= host_gnt ? 1'b1 : acc_gnt ? 1'b0 : ptr_q;
      ovf_q   <= ovf_d;
      vhold_q <= vga_rdata;
      ahold_q <= acc_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= host_addr;
      fd_q[wp_q] <= host_wdata;
    end
  end
endmodule
